// File: rtl/lsu_axi_ctrl_pkg.sv
// Shared constants, state encoding and types for the LSU memory-access stage.
package lsu_pkg;

   localparam int LSU_DATA_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AR   = 3'd1;
   localparam logic [2:0] ST_R    = 3'd2;
   localparam logic [2:0] ST_AWW  = 3'd3;
   localparam logic [2:0] ST_B    = 3'd4;
   localparam logic [2:0] ST_RESP = 3'd5;

   typedef struct packed {
      logic [LSU_DATA_W-1:0] rdata;
      logic [1:0]            low2addr;
      logic [2:0]            func3;
      logic                  err;
   } lsu_resp_t;

   // Illegal func3 for the access direction, or an access that straddles its natural alignment.
   function automatic logic req_bad(input logic wen, input logic [2:0] f3, input logic [1:0] low2);
      logic illegal;
      logic misal;
      if (wen) illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
      else     illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      misal = ((f3[1:0] == 2'b01) && low2[0]) || ((f3[1:0] == 2'b10) && (low2 != 2'b00));
      return illegal | misal;
   endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store lane steering: shifts right-aligned store data into its byte lanes and builds the strobe.
module lsu_store_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]          func3,
   input  logic [1:0]          low2addr,
   input  logic [DATA_W-1:0]   wdata_in,
   output logic [DATA_W-1:0]   wdata_out,
   output logic [DATA_W/8-1:0] wstrb
);

   assign wdata_out = wdata_in << {low2addr, 3'b000};

   always_comb begin
      wstrb = 4'b1111;
      case (func3[1:0])
         F3_B[1:0]: wstrb = 4'b0001 << low2addr;
         F3_H[1:0]: wstrb = 4'b0011 << low2addr;
         default:   wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/lsu_axi_ctrl.sv
// LSU memory-access stage: runs one load/store at a time as an AXI4-Lite master transaction.
module lsu_axi_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [2:0]          req_func3,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic [1:0]          resp_low2addr,
   output logic [2:0]          resp_func3,
   output logic                resp_err,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        func3_q;
   logic              aw_done, w_done;
   logic              aw_done_nxt, w_done_nxt;
   lsu_resp_t         resp_q;
   logic              bad;

   assign bad = req_bad(req_wen, req_func3, req_addr[1:0]);

   // All handshake outputs decode straight from registered state, so they never glitch or drop early.
   assign req_ready  = (state == ST_IDLE);
   assign arvalid    = (state == ST_AR);
   assign rready     = (state == ST_R);
   assign awvalid    = (state == ST_AWW) && !aw_done;
   assign wvalid     = (state == ST_AWW) && !w_done;
   assign bready     = (state == ST_B);
   assign resp_valid = (state == ST_RESP);

   assign araddr = {addr_q[ADDR_W-1:2], 2'b00};
   assign awaddr = {addr_q[ADDR_W-1:2], 2'b00};

   assign resp_rdata    = resp_q.rdata;
   assign resp_low2addr = resp_q.low2addr;
   assign resp_func3    = resp_q.func3;
   assign resp_err      = resp_q.err;

   assign aw_done_nxt = aw_done | (awvalid & awready);
   assign w_done_nxt  = w_done  | (wvalid  & wready);

   lsu_store_align #(.DATA_W(DATA_W)) u_align (
      .func3     (func3_q),
      .low2addr  (addr_q[1:0]),
      .wdata_in  (wdata_q),
      .wdata_out (wdata),
      .wstrb     (wstrb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         func3_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         resp_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q          <= req_addr;
                  wdata_q         <= req_wdata;
                  func3_q         <= req_func3;
                  aw_done         <= 1'b0;
                  w_done          <= 1'b0;
                  resp_q.rdata    <= '0;
                  resp_q.low2addr <= req_addr[1:0];
                  resp_q.func3    <= req_func3;
                  resp_q.err      <= bad;
                  if (bad)          state <= ST_RESP;
                  else if (req_wen) state <= ST_AWW;
                  else              state <= ST_AR;
               end
            end
            ST_AR: if (arready) state <= ST_R;
            ST_R: begin
               if (rvalid) begin
                  resp_q.rdata <= rdata;
                  resp_q.err   <= (rresp != AXI_RESP_OKAY);
                  state        <= ST_RESP;
               end
            end
            ST_AWW: begin
               // AW and W complete independently, possibly in the same cycle.
               aw_done <= aw_done_nxt;
               w_done  <= w_done_nxt;
               if (aw_done_nxt && w_done_nxt) state <= ST_B;
            end
            ST_B: begin
               if (bvalid) begin
                  resp_q.rdata <= '0;
                  resp_q.err   <= (bresp != AXI_RESP_OKAY);
                  state        <= ST_RESP;
               end
            end
            ST_RESP: if (resp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Randomized bench for lsu_axi_ctrl: AXI4-Lite slave with per-channel delays plus a transaction-level model.
module tb_lsu_axi_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_func3 = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_low2addr;
   logic [2:0]  resp_func3;
   logic [31:0] araddr, awaddr, wdata, rdata = '0;
   logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
   logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
   logic        bvalid = 1'b0, bready;
   logic [1:0]  rresp = '0, bresp = '0;
   logic [3:0]  wstrb;

   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   lsu_axi_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_low2addr(resp_low2addr), .resp_func3(resp_func3), .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- slave model (acts on negedges) ----------------
   int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_resp = '0;
   bit          stray = 0;

   int  ar_w = 0, aw_w = 0, w_w = 0, r_cnt = 0, b_cnt = 0;
   bit  r_pend = 0, b_pend = 0, r_on = 0, b_on = 0, aw_got = 0, w_got = 0, both_done = 0;
   bit  ar_fire = 0, r_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
   bit  pv_ar = 0, pv_aw = 0, pv_w = 0;
   logic [31:0] pa_ar = '0, pa_aw = '0, pd_w = '0;
   logic [3:0]  ps_w = '0;
   int  n_ar = 0, n_aw = 0, n_w = 0, axi_viol = 0;
   logic [31:0] got_araddr = '0, got_awaddr = '0, got_wdata = '0;
   logic [3:0]  got_wstrb = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         r_pend = 0; b_pend = 0; r_on = 0; b_on = 0; aw_got = 0; w_got = 0; both_done = 0;
         ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
         pv_ar = 0; pv_aw = 0; pv_w = 0; ar_w = 0; aw_w = 0; w_w = 0;
         arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      end else begin
         if (ar_fire) begin r_pend = 1; r_cnt = r_dly; end
         if (r_fire) r_on = 0;
         if (aw_fire) aw_got = 1;
         if (w_fire) w_got = 1;
         if (aw_got && w_got) begin aw_got = 0; w_got = 0; both_done = 1; b_pend = 1; b_cnt = b_dly; end
         if (b_fire) begin b_on = 0; both_done = 0; end
         if (pv_ar && !ar_fire && (!arvalid || araddr != pa_ar)) axi_viol++;
         if (pv_aw && !aw_fire && (!awvalid || awaddr != pa_aw)) axi_viol++;
         if (pv_w && !w_fire && (!wvalid || wdata != pd_w || wstrb != ps_w)) axi_viol++;
         if (bready && !both_done) axi_viol++;
         pv_ar = arvalid; pa_ar = araddr;
         pv_aw = awvalid; pa_aw = awaddr;
         pv_w = wvalid; pd_w = wdata; ps_w = wstrb;
         if (r_pend) begin if (r_cnt == 0) begin r_on = 1; r_pend = 0; end else r_cnt--; end
         if (b_pend) begin if (b_cnt == 0) begin b_on = 1; b_pend = 0; end else b_cnt--; end
         if (arvalid) begin if (ar_w >= ar_dly) begin arready = 1; ar_w = 0; end else begin arready = 0; ar_w++; end end
         else begin arready = 0; ar_w = 0; end
         if (awvalid) begin if (aw_w >= aw_dly) begin awready = 1; aw_w = 0; end else begin awready = 0; aw_w++; end end
         else begin awready = 0; aw_w = 0; end
         if (wvalid) begin if (w_w >= w_dly) begin wready = 1; w_w = 0; end else begin wready = 0; w_w++; end end
         else begin wready = 0; w_w = 0; end
         rvalid = r_on || stray;
         bvalid = b_on || stray;
         rdata  = s_rdata;
         rresp  = stray ? 2'b10 : s_resp;
         bresp  = stray ? 2'b10 : s_resp;
         ar_fire = arvalid && arready;
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         r_fire  = rvalid && rready;
         b_fire  = bvalid && bready;
         if (ar_fire) begin n_ar++; got_araddr = araddr; end
         if (aw_fire) begin n_aw++; got_awaddr = awaddr; end
         if (w_fire) begin n_w++; got_wdata = wdata; got_wstrb = wstrb; end
      end
   end

   // ---------------- reference model + driver ----------------
   task automatic resp_fields(input string tag, input logic [31:0] er, input logic [1:0] el,
                              input logic [2:0] ef, input logic ee);
      chk({tag, "_valid"}, resp_valid, 1);
      chk({tag, "_rdata"}, resp_rdata, er);
      chk({tag, "_low2"}, resp_low2addr, el);
      chk({tag, "_func3"}, resp_func3, ef);
      chk({tag, "_err"}, resp_err, ee);
   endtask

   task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input int ard, input int rd, input int awd,
                          input int wdd, input int bd, input int rrd, input logic [1:0] rsp,
                          input logic [31:0] rdat, input bit chk_lat);
      bit          illegal, mis, bad;
      int          size, low2, cyc, n_ar0, n_aw0, n_w0, viol0;
      logic [31:0] exp_waddr, exp_wdata, exp_rdata;
      logic [3:0]  exp_strb;
      logic        exp_err;
      illegal   = wen ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7});
      size      = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      low2      = int'(addr % 4);
      mis       = !illegal && (low2 % size != 0);
      bad       = illegal || mis;
      exp_waddr = addr - 32'(low2);
      exp_wdata = 32'(64'(wd) * (64'd1 << (8 * low2)));
      exp_strb  = 4'(((1 << size) - 1) << low2);
      exp_err   = bad ? 1'b1 : (rsp != 2'b00);
      exp_rdata = (bad || wen) ? 32'h0 : rdat;
      ar_dly = ard; r_dly = rd; aw_dly = awd; w_dly = wdd; b_dly = bd;
      s_resp = rsp; s_rdata = rdat;
      n_ar0 = n_ar; n_aw0 = n_aw; n_w0 = n_w; viol0 = axi_viol;

      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_func3 = f3;
      @(negedge clk);
      req_valid = 0; req_wen = $urandom; req_addr = $urandom; req_wdata = $urandom; req_func3 = 3'($urandom);
      cyc = 1;
      while (!resp_valid && cyc < 100) begin @(negedge clk); cyc++; end
      chk("resp_timeout", resp_valid, 1);
      if (chk_lat) chk("latency", cyc, bad ? 1 : 3);
      for (int i = 0; i < rrd; i++) begin
         resp_fields("resp_hold", exp_rdata, 2'(low2), f3, exp_err);
         chk("req_ready_busy", req_ready, 0);
         @(negedge clk);
      end
      resp_fields("resp", exp_rdata, 2'(low2), f3, exp_err);
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      chk("resp_drop", resp_valid, 0);
      chk("req_ready_back", req_ready, 1);
      chk("n_ar", n_ar - n_ar0, (!bad && !wen) ? 1 : 0);
      chk("n_aw", n_aw - n_aw0, (!bad && wen) ? 1 : 0);
      chk("n_w", n_w - n_w0, (!bad && wen) ? 1 : 0);
      if (!bad && !wen) chk("araddr", got_araddr, exp_waddr);
      if (!bad && wen) begin
         chk("awaddr", got_awaddr, exp_waddr);
         chk("wdata", got_wdata, exp_wdata);
         chk("wstrb", got_wstrb, exp_strb);
      end
      chk("axi_rules", axi_viol - viol0, 0);
   endtask

   initial begin
      bit          saw_resp;
      int          cyc;
      logic [1:0]  rsp;
      int          ard, rd, awd, wdd, bd;
      bit          zero;

      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_low2", resp_low2addr, 0);
      chk("rst_resp_func3", resp_func3, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_wdata", wdata, 0);
      @(negedge clk);
      #2 rst_n = 1;

      // directed cases
      run_txn(0, 32'h8000_0004, 32'h0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1);
      chk("lw_araddr", got_araddr, 32'h8000_0004);
      run_txn(1, 32'h8000_0003, 32'h0000_00A5, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1);
      chk("sb_awaddr", got_awaddr, 32'h8000_0000);
      chk("sb_wdata", got_wdata, 32'hA500_0000);
      chk("sb_wstrb", got_wstrb, 4'b1000);
      run_txn(1, 32'h8000_0001, 32'h1234_5678, 3'b001, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1);
      run_txn(1, 32'h8000_0010, 32'hCAFE_F00D, 3'b010, 0, 0, 1, 3, 0, 0, 2'b00, 32'h0, 0);
      run_txn(0, 32'h8000_0022, 32'h0, 3'b100, 0, 0, 0, 0, 0, 4, 2'b10, 32'h1122_3344, 0);

      // stray R/B beats while idle must be ignored
      @(posedge clk); stray = 1;
      @(negedge clk);
      @(negedge clk);
      chk("stray_req_ready", req_ready, 1);
      chk("stray_resp_valid", resp_valid, 0);
      @(posedge clk); stray = 0;
      @(negedge clk);

      // reset while waiting in R abandons the load
      ar_dly = 0; r_dly = 6; s_resp = 2'b00; s_rdata = 32'h5555_AAAA;
      @(negedge clk);
      req_valid = 1; req_wen = 0; req_addr = 32'h8000_0040; req_func3 = 3'b010;
      @(negedge clk);
      req_valid = 0;
      cyc = 0;
      while (!rready && cyc < 20) begin @(negedge clk); cyc++; end
      chk("reach_r", rready, 1);
      #2 rst_n = 0;
      #1;
      chk("abort_arvalid", arvalid, 0);
      chk("abort_rready", rready, 0);
      chk("abort_awvalid", awvalid, 0);
      chk("abort_wvalid", wvalid, 0);
      chk("abort_bready", bready, 0);
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_req_ready", req_ready, 1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1;
      saw_resp = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (resp_valid || !req_ready) saw_resp = 1; end
      chk("abort_no_resp", saw_resp, 0);
      run_txn(0, 32'h8000_0044, 32'h0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, 1);

      // randomized traffic
      for (int t = 0; t < 250; t++) begin
         zero = ($urandom % 3 == 0);
         ard = zero ? 0 : int'($urandom % 4);
         rd  = zero ? 0 : int'($urandom % 4);
         awd = zero ? 0 : int'($urandom % 4);
         wdd = zero ? 0 : int'($urandom % 4);
         bd  = zero ? 0 : int'($urandom % 4);
         rsp = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
         run_txn(1'($urandom), $urandom, $urandom, 3'($urandom), ard, rd, awd, wdd, bd,
                 int'($urandom % 4), rsp, $urandom, zero);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
